cgra_config_tile_receiver: RTL and testbench
============================================

# cgra_config_tile_receiver

Synthesizable per-tile configuration receiver: the responder end of the CGRA global config bus (`config_addr_in` / `config_data_in`) that the full-system bench and the config loader drive. It filters bus transactions by tile ID and decodes an opcode. Writes go to a shadow register bank, which is committed atomically to an active bank that drives the tile's datapath, and reads are answered with registered data. One instance sits in each tile beside the switch box / PE config ports.

## Interface
Parameters:
- `TILE_ID`, 16'h0000: tile address matched against `config_addr_in[15:0]`.
- `NUM_REGS`, 8: number of 32-bit config registers. Range 1..128.

Ports:
- `clk_in`, input, 1: single clock. All state changes on the rising edge.
- `reset_in`, input, 1: reset, asynchronous, active-low. Clears all state.
- `config_en_in`, input, 1: transaction valid, one transaction per cycle it is high.
- `config_addr_in`, input, 32: [15:0] tile ID, [22:16] register index, [23] read bank select (1 = active bank), [31:24] opcode.
- `config_data_in`, input, 32: write data.
- `cfg_active_out`, output, `NUM_REGS*32`: active bank, register i at bits [32*i+31:32*i].
- `read_data_out`, output, 32: readback data.
- `read_valid_out`, output, 1: one-cycle pulse qualifying `read_data_out`.
- `committed_out`, output, 1: sticky flag, set by the first commit since reset.
- `error_count_out`, output, 8: saturating count of rejected transactions addressed to this tile.

## Operation
- A transaction is **accepted** when `config_en_in`=1 and `config_addr_in[15:0]==TILE_ID`. All other cycles are ignored entirely: no state change and no error count.
- Opcodes on accepted transactions:
  - 8'h00 WRITE: `shadow[idx] <= config_data_in`.
  - 8'h01 READ: return `active[idx]` if bit 23=1, else `shadow[idx]`.
  - 8'h02 COMMIT: `active[k] <= shadow[k]` for all k, and `committed_out <= 1`. Index and data are ignored.
  - 8'h03 CLEAR: `shadow[k] <= 0` for all k. The active bank is unchanged.
  - Any other opcode: no effect, error count +1.
- Index range check applies to WRITE and READ. If `idx >= NUM_REGS`:
  - WRITE is dropped and error count +1.
  - READ still pulses `read_valid_out` with `read_data_out`=0, and error count +1.
- `error_count_out` saturates at 8'hFF and holds there.
- The active bank changes only on COMMIT. The datapath never sees a partially written configuration.
- Reset (any time, including mid-sequence): both banks 0, `read_data_out`=0, `read_valid_out`=0, `committed_out`=0, `error_count_out`=0. A pending read response is discarded.

## Timing
- WRITE/CLEAR accepted at edge N: the shadow bank shows the update after edge N. A READ of the shadow accepted at edge N+1 returns the new value.
- READ accepted at edge N: `read_valid_out`=1 and `read_data_out` valid for exactly the cycle after edge N. Latency is 1. `read_data_out` holds its last value when `read_valid_out`=0.
- Back-to-back READs on consecutive cycles produce consecutive `read_valid_out` pulses. There is no stall and no backpressure.
- COMMIT accepted at edge N: `cfg_active_out` and `committed_out` update after edge N.
- READ of the active bank at edge N+1 returns the committed value.
- A WRITE accepted in the cycle after a COMMIT does not affect the active bank.
- Error count increments after the edge at which the rejected transaction was accepted.
- Reset deassertion is synchronous to `clk_in` in the integrating design. The first transaction can be accepted at the first rising edge after deassertion.

## Test plan
- Reset check: assert `reset_in`=0 mid-run after writes and a commit. Required response: all outputs 0 immediately, without waiting for a clock edge.
- Write/commit: WRITE reg 2 = 32'h0000_0003 with TILE_ID match.
  - READ shadow reg 2: read data 3 one cycle later.
  - READ active reg 2: 0.
  - COMMIT: `cfg_active_out[95:64]`=3 and `committed_out`=1.
- Tile filter: WRITE with tile ID = TILE_ID+1 and data 32'hDEAD_BEEF. Required response: shadow unchanged and `error_count_out` unchanged.
- Errors and saturation:
  - READ idx=NUM_REGS: read data 0, valid pulse, count 1.
  - Opcode 8'h7F: count 2.
  - 300 bad opcodes: count holds at 255.
- Atomicity:
  - COMMIT shadow {1..8}, CLEAR, then WRITE reg 0 = 9. Required response: active bank still {1..8}.
  - COMMIT again: active = {9, 0, ..., 0}.
- Streaming reads: READs on 4 consecutive cycles for regs 0..3. Required response: 4 consecutive valid pulses with the matching data, in order.

Source files
------------

// File: rtl/cgra_config_tile_receiver.sv
// cgra_config_tile_receiver: per-tile config bus responder with a shadow bank that
// commits atomically to the active bank, plus registered readback and error counting.
module cgra_config_tile_receiver #(
    parameter logic [15:0] TILE_ID  = 16'h0000,
    parameter int          NUM_REGS = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  config_en_in,
    input  logic [31:0]           config_addr_in,
    input  logic [31:0]           config_data_in,
    output logic [NUM_REGS*32-1:0] cfg_active_out,
    output logic [31:0]           read_data_out,
    output logic                  read_valid_out,
    output logic                  committed_out,
    output logic [7:0]            error_count_out
);
    localparam int         IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NR = 8'(NUM_REGS);

    logic [31:0] shadow_q [NUM_REGS];
    logic [31:0] shadow_d [NUM_REGS];
    logic [31:0] active_q [NUM_REGS];
    logic [31:0] active_d [NUM_REGS];
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        committed_q, committed_d;
    logic [7:0]  err_q, err_d;
    logic        acc, idx_ok, bad;
    logic [6:0]  idx;
    logic [7:0]  op;
    logic [IW-1:0] sel;

    assign acc    = config_en_in && (config_addr_in[15:0] == TILE_ID);
    assign idx    = config_addr_in[22:16];
    assign op     = config_addr_in[31:24];
    assign idx_ok = {1'b0, idx} < NR;
    assign sel    = idx[IW-1:0];

    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        committed_d = committed_q;
        bad         = 1'b0;
        if (acc) begin
            case (op)
                8'h00: begin
                    if (idx_ok) shadow_d[sel] = config_data_in;
                    bad = !idx_ok;
                end
                8'h01: begin
                    rvalid_d = 1'b1;
                    rdata_d  = !idx_ok ? '0 : config_addr_in[23] ? active_q[sel] : shadow_q[sel];
                    bad      = !idx_ok;
                end
                8'h02: begin
                    active_d    = shadow_q;
                    committed_d = 1'b1;
                end
                8'h03: for (int k = 0; k < NUM_REGS; k++) shadow_d[k] = '0;
                default: bad = 1'b1;
            endcase
        end
        err_d = (bad && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            committed_q <= 1'b0;
            err_q       <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            committed_q <= committed_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign cfg_active_out[32*g +: 32] = active_q[g];
    end

    assign read_data_out   = rdata_q;
    assign read_valid_out  = rvalid_q;
    assign committed_out   = committed_q;
    assign error_count_out = err_q;
endmodule

// File: tb/tb_cgra_config_tile_receiver.sv
// tb_cgra_config_tile_receiver: directed stimulus with a read-response scoreboard
// checked by an independent monitor, plus direct checks of bank/flag/counter state.
module tb_cgra_config_tile_receiver;
    localparam logic [15:0] TILE = 16'h00A5;
    localparam int          NR   = 8;
    localparam logic [7:0]  OP_WR = 8'h00, OP_RD = 8'h01, OP_CM = 8'h02, OP_CL = 8'h03;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       data = '0;
    logic [NR*32-1:0]  active;
    logic [31:0]       rdata;
    logic              rvalid, committed;
    logic [7:0]        errc;

    int n_cmp = 0;
    int n_bad = 0;
    int run = 0;
    int max_run = 0;
    logic [31:0] exp_q [$];
    logic [NR*32-1:0] exp_act;

    cgra_config_tile_receiver #(.TILE_ID(TILE), .NUM_REGS(NR)) dut (
        .clk_in(clk), .reset_in(rst_n), .config_en_in(en), .config_addr_in(addr),
        .config_data_in(data), .cfg_active_out(active), .read_data_out(rdata),
        .read_valid_out(rvalid), .committed_out(committed), .error_count_out(errc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tx(input logic [7:0] op, input logic bank, input logic [6:0] idx,
                      input logic [15:0] tile, input logic [31:0] d);
        en   = 1'b1;
        addr = {op, bank, idx, tile};
        data = d;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic rd(input logic bank, input logic [6:0] idx, input logic [31:0] exp);
        exp_q.push_back(exp);
        tx(OP_RD, bank, idx, TILE, '0);
    endtask

    // Monitor: pops one expected response per valid pulse and tracks pulse run length.
    always @(negedge clk) begin
        if (rvalid) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) chk("unexpected_read", {224'd0, rdata}, '1);
            else chk("read_data", {224'd0, rdata}, {224'd0, exp_q.pop_front()});
        end else run = 0;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_active", active, '0);
        chk("rst_rdata", {224'd0, rdata}, '0);
        chk("rst_flags", {254'd0, rvalid, committed}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        tx(OP_WR, 1'b0, 7'd2, TILE, 32'h0000_0003);
        rd(1'b0, 7'd2, 32'd3);
        rd(1'b1, 7'd2, 32'd0);
        tx(OP_CM, 1'b0, 7'd0, TILE, '0);
        chk("commit_reg2", {224'd0, active[95:64]}, 256'd3);
        chk("committed", {255'd0, committed}, 256'd1);

        tx(OP_WR, 1'b0, 7'd2, TILE + 16'd1, 32'hDEAD_BEEF);
        rd(1'b0, 7'd2, 32'd3);
        chk("filter_err", {248'd0, errc}, '0);

        rd(1'b0, 7'(NR), 32'd0);
        chk("rd_oob_err", {248'd0, errc}, 256'd1);
        tx(8'h7F, 1'b0, 7'd0, TILE, '0);
        chk("bad_op_err", {248'd0, errc}, 256'd2);
        tx(OP_WR, 1'b0, 7'd100, TILE, 32'h1234_5678);
        chk("wr_oob_err", {248'd0, errc}, 256'd3);

        exp_act = '0;
        for (int i = 0; i < NR; i++) begin
            tx(OP_WR, 1'b0, 7'(i), TILE, 32'(i + 1));
            exp_act[32*i +: 32] = 32'(i + 1);
        end
        chk("pre_commit_hold", {224'd0, active[95:64]}, 256'd3);
        tx(OP_CM, 1'b0, 7'd0, TILE, '0);
        chk("commit_1to8", active, exp_act);
        tx(OP_CL, 1'b0, 7'd0, TILE, '0);
        tx(OP_WR, 1'b0, 7'd0, TILE, 32'd9);
        chk("atomic_hold", active, exp_act);
        rd(1'b0, 7'd1, 32'd0);
        rd(1'b1, 7'd1, 32'd2);
        tx(OP_CM, 1'b0, 7'd0, TILE, '0);
        chk("commit_after_clear", active, {{(NR-1)*32{1'b0}}, 32'd9});

        tx(OP_WR, 1'b0, 7'd0, TILE, 32'hA0A0_0001);
        tx(OP_WR, 1'b0, 7'd1, TILE, 32'hB1B1_0002);
        tx(OP_WR, 1'b0, 7'd2, TILE, 32'hC2C2_0003);
        tx(OP_WR, 1'b0, 7'd3, TILE, 32'hD3D3_0004);
        max_run = 0;
        rd(1'b0, 7'd0, 32'hA0A0_0001);
        rd(1'b0, 7'd1, 32'hB1B1_0002);
        rd(1'b0, 7'd2, 32'hC2C2_0003);
        rd(1'b0, 7'd3, 32'hD3D3_0004);
        @(negedge clk);
        @(negedge clk);
        chk("stream_run", 256'(max_run), 256'd4);

        for (int i = 0; i < 300; i++) tx(8'hFF, 1'b0, 7'd0, TILE, '0);
        chk("err_saturate", {248'd0, errc}, 256'hFF);
        rd(1'b0, 7'd127, 32'd0);
        chk("err_hold", {248'd0, errc}, 256'hFF);

        tx(OP_RD, 1'b1, 7'd0, TILE, '0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_active", active, '0);
        chk("mid_rst_rdata", {224'd0, rdata}, '0);
        chk("mid_rst_flags", {254'd0, rvalid, committed}, '0);
        chk("mid_rst_err", {248'd0, errc}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(1'b0, 7'd3, 32'd0);
        rd(1'b1, 7'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 256'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
